sequence_generator: RTL and testbench



---
 rtl/sequence_generator.sv | 168 ++++++++++++++++
 tb/tb_sequence_generator.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: captures a pattern word on START and shifts it
// out MSB-first (PATTERN[LEN-1] first), repeating REPEAT+1 times with GAP
// idle cycles between repetitions.
// Ports:
//   CLK, RST         rising-edge clock, synchronous active-high reset
//   START            begin a transmission (accepted only while idle)
//   PATTERN, LEN     pattern bits and bits per repetition (0 or >WIDTH -> WIDTH)
//   REPEAT, GAP      extra repetitions and idle cycles between repetitions
//   X, VALID         serial bit and its qualifier (registered)
//   BUSY, DONE       transmission in progress / one-cycle completion pulse
module sequence_generator #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned CNT_W = 4,
   localparam int unsigned LW    = $clog2(WIDTH) + 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] PATTERN,
   input  logic [LW-1:0]    LEN,
   input  logic [CNT_W-1:0] REPEAT,
   input  logic [1:0]       GAP,
   output logic             X,
   output logic             VALID,
   output logic             BUSY,
   output logic             DONE
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;         // remaining bits, next bit at MSB
   logic [WIDTH-1:0] pat_q, pat_d;       // left-aligned copy for reloads
   logic [LW-1:0]    len_q, len_d;
   logic [LW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] rep_q, rep_d;
   logic [1:0]       gap_q, gap_d;
   logic [1:0]       gap_cnt_q, gap_cnt_d;
   logic             x_q, x_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [LW-1:0]    len_clamp_c;
   logic [WIDTH-1:0] align_c;

   // Clamp LEN and left-align the pattern so its first bit sits at the MSB
   always_comb begin
      len_clamp_c = LEN;
      if (LEN == '0 || LEN > LW'(WIDTH)) begin
         len_clamp_c = LW'(WIDTH);
      end
      align_c = PATTERN << (LW'(WIDTH) - len_clamp_c);
   end

   // State and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         sh_q      <= '0;
         pat_q     <= '0;
         len_q     <= '0;
         bit_cnt_q <= '0;
         rep_q     <= '0;
         gap_q     <= '0;
         gap_cnt_q <= '0;
         x_q       <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         pat_q     <= pat_d;
         len_q     <= len_d;
         bit_cnt_q <= bit_cnt_d;
         rep_q     <= rep_d;
         gap_q     <= gap_d;
         gap_cnt_q <= gap_cnt_d;
         x_q       <= x_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next state: the registered outputs describe the cycle after each edge
   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      pat_d     = pat_q;
      len_d     = len_q;
      bit_cnt_d = bit_cnt_q;
      rep_d     = rep_q;
      gap_d     = gap_q;
      gap_cnt_d = gap_cnt_q;
      x_d       = 1'b0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               pat_d     = align_c;
               len_d     = len_clamp_c;
               rep_d     = REPEAT;
               gap_d     = GAP;
               x_d       = align_c[WIDTH-1];
               sh_d      = {align_c[WIDTH-2:0], 1'b0};
               bit_cnt_d = LW'(1);
               valid_d   = 1'b1;
               busy_d    = 1'b1;
               state_d   = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (bit_cnt_q < len_q) begin
               x_d       = sh_q[WIDTH-1];
               sh_d      = {sh_q[WIDTH-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + LW'(1);
               valid_d   = 1'b1;
               busy_d    = 1'b1;
            end else if (rep_q != '0) begin
               rep_d  = rep_q - CNT_W'(1);
               busy_d = 1'b1;
               if (gap_q == 2'd0) begin
                  x_d       = pat_q[WIDTH-1];
                  sh_d      = {pat_q[WIDTH-2:0], 1'b0};
                  bit_cnt_d = LW'(1);
                  valid_d   = 1'b1;
               end else begin
                  sh_d      = pat_q;
                  gap_cnt_d = 2'd1;
                  state_d   = S_GAP;
               end
            end else begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end

         S_GAP: begin
            busy_d = 1'b1;
            if (gap_cnt_q < gap_q) begin
               gap_cnt_d = gap_cnt_q + 2'd1;
            end else begin
               x_d       = sh_q[WIDTH-1];
               sh_d      = {sh_q[WIDTH-2:0], 1'b0};
               bit_cnt_d = LW'(1);
               valid_d   = 1'b1;
               state_d   = S_SHIFT;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign X     = x_q;
   assign VALID = valid_q;
   assign BUSY  = busy_q;
   assign DONE  = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Testbench for sequence_generator: a stream model builds the expected
// {X,VALID,BUSY,DONE} sequence for each accepted START and is compared every
// cycle; directed scenarios add hand-computed literal expectations.
module tb_sequence_generator;

   logic       CLK = 1'b0;
   logic       RST;
   logic       START;
   logic [7:0] PATTERN;
   logic [3:0] LEN;
   logic [3:0] REPEAT;
   logic [1:0] GAP;
   logic       X, VALID, BUSY, DONE;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   logic [3:0] exp_q[$];   // expected {X,VALID,BUSY,DONE} per cycle

   sequence_generator #(.WIDTH(8), .CNT_W(4)) dut (
      .CLK(CLK), .RST(RST), .START(START), .PATTERN(PATTERN), .LEN(LEN),
      .REPEAT(REPEAT), .GAP(GAP), .X(X), .VALID(VALID), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stream model: at each edge retire the previous cycle's entry; when idle
   // (nothing pending) a START expands into the whole expected transmission.
   always @(posedge CLK) begin
      int unsigned l;
      if (RST) begin
         exp_q.delete();
      end else begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         if (exp_q.size() == 0 && START) begin
            l = (LEN == 0 || LEN > 8) ? 8 : int'(LEN);
            for (int r = 0; r <= int'(REPEAT); r++) begin
               for (int i = 0; i < int'(l); i++)
                  exp_q.push_back({PATTERN[l-1-i], 3'b110});
               if (r < int'(REPEAT))
                  for (int g = 0; g < int'(GAP); g++) exp_q.push_back(4'b0010);
            end
            exp_q.push_back(4'b0001);
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge CLK) begin
      if (started)
         check("model", {28'd0, X, VALID, BUSY, DONE},
               {28'd0, (exp_q.size() > 0) ? exp_q[0] : 4'b0000});
   end

   task automatic send(input logic [7:0] p, input logic [3:0] l,
                       input logic [3:0] rep, input logic [1:0] g);
      PATTERN = p; LEN = l; REPEAT = rep; GAP = g; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   initial begin
      logic [17:0] xs18;
      logic [23:0] xs24;
      int busy_cnt, valid_cnt, done_seen;

      RST = 1'b1; START = 1'b0; PATTERN = '0; LEN = '0; REPEAT = '0; GAP = '0;
      @(posedge CLK);
      started = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      check("reset_outputs", {28'd0, X, VALID, BUSY, DONE}, 32'd0);
      RST = 1'b0;
      repeat (10) @(negedge CLK);
      check("idle_outputs", {28'd0, X, VALID, BUSY, DONE}, 32'd0);

      // Basic: three ones, then DONE
      send(8'h07, 4'd3, 4'd0, 2'd0);
      for (int i = 0; i < 4; i++) begin
         check("basic", {28'd0, X, VALID, BUSY, DONE}, (i < 3) ? 32'he : 32'h1);
         @(negedge CLK);
      end
      check("basic_after", {28'd0, X, VALID, BUSY, DONE}, 32'd0);
      repeat (2) @(negedge CLK);

      // Repeat with gap
      send(8'hA5, 4'd8, 4'd1, 2'd2);
      xs18 = '0; busy_cnt = 0; valid_cnt = 0;
      for (int i = 0; i < 18; i++) begin
         xs18 = {xs18[16:0], X};
         busy_cnt += int'(BUSY);
         valid_cnt += int'(VALID);
         @(negedge CLK);
      end
      check("gap_bits", {14'd0, xs18}, {14'd0, 18'b10100101_00_10100101});
      check("gap_busy_len", busy_cnt, 18);
      check("gap_valid_len", valid_cnt, 16);
      check("gap_done", {28'd0, X, VALID, BUSY, DONE}, 32'h1);
      repeat (2) @(negedge CLK);

      // Clamp LEN=0 to 8, three back-to-back repetitions
      send(8'hF0, 4'd0, 4'd2, 2'd0);
      xs24 = '0; busy_cnt = 0;
      for (int i = 0; i < 24; i++) begin
         xs24 = {xs24[22:0], X};
         busy_cnt += int'(VALID);
         @(negedge CLK);
      end
      check("clamp_bits", {8'd0, xs24}, 32'hF0F0F0);
      check("clamp_valid_len", busy_cnt, 24);
      check("clamp_done", {28'd0, X, VALID, BUSY, DONE}, 32'h1);
      // START in the DONE cycle, single-bit pattern
      send(8'h01, 4'd1, 4'd0, 2'd0);
      check("b2b_bit", {28'd0, X, VALID, BUSY, DONE}, 32'he);
      @(negedge CLK);
      check("b2b_done", {28'd0, X, VALID, BUSY, DONE}, 32'h1);
      repeat (2) @(negedge CLK);

      // Ignore START while busy, then abort with RST (RST wins over START)
      send(8'hC3, 4'd8, 4'd0, 2'd0);
      PATTERN = 8'hFF; LEN = 4'd2; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      check("ignore_bit1", {28'd0, X, VALID, BUSY, DONE}, 32'he);
      @(negedge CLK);
      check("ignore_bit2", {28'd0, X, VALID, BUSY, DONE}, 32'h6);
      RST = 1'b1; START = 1'b1;
      @(negedge CLK);
      check("abort_outputs", {28'd0, X, VALID, BUSY, DONE}, 32'd0);
      RST = 1'b0; START = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         done_seen += int'(DONE);
         @(negedge CLK);
      end
      check("abort_no_done", done_seen, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
